// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register ids, default widths, instruction codes
// and the dump sequencer state encoding.
package y86_pkg;

   localparam int DATA_W_DFLT = 64;
   localparam int RID_W_DFLT  = 4;
   localparam int NREGS_DFLT  = 15;

   typedef logic [3:0] reg_id_t;

   localparam reg_id_t RNONE = 4'hF;
   localparam reg_id_t RRSP  = 4'h4;

   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_t;

   typedef enum logic [0:0] {
      DUMP_IDLE = 1'b0,
      DUMP_SEND = 1'b1
   } dump_state_t;

endpackage

// File: rtl/y86_regfile_2r2w_if.sv
// Register-file bus: two read ports, E/M write ports and the serial dump channel.
// master = pipeline/consumer side, slave = register file.
interface y86_regfile_2r2w_if #(
   parameter int DATA_W = 64,
   parameter int RID_W  = 4
);
   logic [RID_W-1:0]  srcA;
   logic [RID_W-1:0]  srcB;
   logic [DATA_W-1:0] valA;
   logic [DATA_W-1:0] valB;
   logic              wr_en;
   logic [RID_W-1:0]  dstE;
   logic [DATA_W-1:0] valE;
   logic [RID_W-1:0]  dstM;
   logic [DATA_W-1:0] valM;
   logic              dump_start;
   logic              dump_busy;
   logic              dump_valid;
   logic              dump_ready;
   logic [RID_W-1:0]  dump_idx;
   logic [DATA_W-1:0] dump_data;
   logic              dump_last;

   modport master (
      output srcA, srcB, wr_en, dstE, valE, dstM, valM, dump_start, dump_ready,
      input  valA, valB, dump_busy, dump_valid, dump_idx, dump_data, dump_last
   );

   modport slave (
      input  srcA, srcB, wr_en, dstE, valE, dstM, valM, dump_start, dump_ready,
      output valA, valB, dump_busy, dump_valid, dump_idx, dump_data, dump_last
   );
endinterface

// File: rtl/y86_regfile_dump_fsm.sv
// Serial dump sequencer: walks reg[0..NREGS-1] one beat per valid/ready
// handshake, reading the array through an index/data pair.
module y86_regfile_dump_fsm #(
   parameter int DATA_W = 64,
   parameter int NREGS  = 15,
   parameter int RID_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dump_start,
   input  logic              dump_ready,
   output logic [RID_W-1:0]  rd_idx,
   input  logic [DATA_W-1:0] rd_data,
   output logic              dump_busy,
   output logic              dump_valid,
   output logic              dump_last,
   output logic [RID_W-1:0]  dump_idx,
   output logic [DATA_W-1:0] dump_data
);
   import y86_pkg::*;

   localparam logic [RID_W-1:0] LAST_IDX = RID_W'(NREGS - 1);

   dump_state_t      state_q;
   dump_state_t      state_d;
   logic [RID_W-1:0] idx_q;
   logic [RID_W-1:0] idx_d;

   // Next state and index; index parks at 0 whenever idle
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         DUMP_IDLE: begin
            idx_d = '0;
            if (dump_start) begin
               state_d = DUMP_SEND;
            end else begin
               state_d = DUMP_IDLE;
            end
         end
         DUMP_SEND: begin
            if (dump_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DUMP_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + RID_W'(1);
               end
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            state_d = DUMP_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State and index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DUMP_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Channel outputs decoded straight from the state flops
   always_comb begin
      rd_idx     = idx_q;
      dump_idx   = idx_q;
      dump_valid = (state_q == DUMP_SEND);
      dump_busy  = (state_q == DUMP_SEND);
      dump_last  = (state_q == DUMP_SEND) && (idx_q == LAST_IDX);
      if (state_q == DUMP_SEND) begin
         dump_data = rd_data;
      end else begin
         dump_data = '0;
      end
   end

endmodule

// File: rtl/y86_regfile_2r2w.sv
// Y86-64 register file: two combinational read ports with optional write
// bypass, two clocked write ports (M wins on collision) and a serial dump.
module y86_regfile_2r2w #(
   parameter int               DATA_W    = 64,
   parameter int               NREGS     = 15,
   parameter int               RID_W     = 4,
   parameter logic [RID_W-1:0] RNONE     = 4'hF,
   parameter bit               BYPASS    = 1'b1,
   parameter bit               RESET_IDX = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   y86_regfile_2r2w_if.slave    rf
);
   import y86_pkg::*;

   localparam bit BYP_EN = (BYPASS != 1'b0);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [RID_W-1:0]  rd_id  [2];
   logic [DATA_W-1:0] rd_val [2];
   logic              we_e;
   logic              we_m;
   logic [RID_W-1:0]  dump_rd_idx;
   logic [DATA_W-1:0] dump_rd_data;

   function automatic logic id_ok(input logic [RID_W-1:0] id);
      return (id != RNONE) && (int'(id) < NREGS);
   endfunction

   assign we_e     = rf.wr_en && id_ok(rf.dstE);
   assign we_m     = rf.wr_en && id_ok(rf.dstM);
   assign rd_id[0] = rf.srcA;
   assign rd_id[1] = rf.srcB;
   assign rf.valA  = rd_val[0];
   assign rf.valB  = rd_val[1];

   // Next array contents; M is tested first so it wins a dstE==dstM collision
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         if (we_m && (int'(rf.dstM) == i)) begin
            regs_d[i] = rf.valM;
         end else if (we_e && (int'(rf.dstE) == i)) begin
            regs_d[i] = rf.valE;
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   // Register array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= (RESET_IDX != 1'b0) ? DATA_W'(i) : '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read ports with same-cycle bypass, M taking priority over E
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         if (!id_ok(rd_id[p])) begin
            rd_val[p] = '0;
         end else if (BYP_EN && we_m && (rd_id[p] == rf.dstM)) begin
            rd_val[p] = rf.valM;
         end else if (BYP_EN && we_e && (rd_id[p] == rf.dstE)) begin
            rd_val[p] = rf.valE;
         end else begin
            rd_val[p] = regs_q[rd_id[p]];
         end
      end
   end

   // Dump reads stored contents only, never the bypass path
   always_comb begin
      if (id_ok(dump_rd_idx)) begin
         dump_rd_data = regs_q[dump_rd_idx];
      end else begin
         dump_rd_data = '0;
      end
   end

   y86_regfile_dump_fsm #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .RID_W  (RID_W)
   ) u_dump (
      .clk        (clk),
      .rst_n      (rst_n),
      .dump_start (rf.dump_start),
      .dump_ready (rf.dump_ready),
      .rd_idx     (dump_rd_idx),
      .rd_data    (dump_rd_data),
      .dump_busy  (rf.dump_busy),
      .dump_valid (rf.dump_valid),
      .dump_last  (rf.dump_last),
      .dump_idx   (rf.dump_idx),
      .dump_data  (rf.dump_data)
   );

endmodule
